shot_scorer: RTL

Downstream consumer of the kinematic stage's ball position. Samples `ball_x`/`ball_y` once per video frame and tracks each shot from launch to resolution. Declares a make when the ball crosses the rim line moving downward inside the rim window, and a miss when it reaches the floor or leaves the right edge. Keeps two-digit BCD made/attempted counters for the seven-segment display, plus one-cycle result pulses.

---
 rtl/shot_scorer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/shot_scorer.sv
// Shot scorer: tracks a shot per frame_tick from launch to make/miss and keeps BCD score/attempt counters.
// Optional feature macro: SHOT_POINTS_EN (2/3-point scoring from the launch position).
module shot_scorer #(
    parameter int RIM_X_LO    = 540,
    parameter int RIM_X_HI    = 580,
    parameter int RIM_Y       = 200,
    parameter int FLOOR_Y     = 470,
    parameter int SCREEN_W    = 640,
    parameter int HOLD_FRAMES = 60
`ifdef SHOT_POINTS_EN
    ,
    parameter int THREE_PT_X  = 320
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic [7:0] score_bcd,
    output logic [7:0] shots_bcd,
    output logic       made,
    output logic       missed,
    output logic       flash,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES - 1);
    localparam logic [9:0] RIM_X_LO_V = 10'(RIM_X_LO);
    localparam logic [9:0] RIM_X_HI_V = 10'(RIM_X_HI);
    localparam logic [9:0] RIM_Y_V    = 10'(RIM_Y);
    localparam logic [9:0] FLOOR_Y_V  = 10'(FLOOR_Y);
    localparam logic [9:0] SCREEN_W_V = 10'(SCREEN_W);

    // Digit-wise saturating BCD add; n never exceeds 3, so at most one carry out of the ones digit.
    function automatic logic [7:0] bcd_add(input logic [7:0] v, input logic [3:0] n);
        logic [4:0] ones;
        logic [4:0] tens;
        ones = {1'b0, v[3:0]} + {1'b0, n};
        tens = {1'b0, v[7:4]};
        if (ones > 5'd9) begin
            ones = ones - 5'd10;
            tens = tens + 5'd1;
        end
        if (tens > 5'd9) return 8'h99;
        return {tens[3:0], ones[3:0]};
    endfunction

    state_t        state, state_n;
    logic [9:0]    prev_y, prev_y_n;
    logic          prev_valid, prev_valid_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [7:0]    score_n, shots_n;
    logic          made_n, missed_n, flash_n;
    logic          hit, out_of_play;
    logic [3:0]    pts;

    // Only the vertical history matters: a make needs the previous sample above the rim line.
    assign hit = prev_valid && (prev_y < RIM_Y_V) && (ball_y >= RIM_Y_V)
                 && (ball_x >= RIM_X_LO_V) && (ball_x <= RIM_X_HI_V);
    assign out_of_play = (ball_y >= FLOOR_Y_V) || (ball_x >= SCREEN_W_V);

`ifdef SHOT_POINTS_EN
    localparam logic [9:0] THREE_PT_X_V = 10'(THREE_PT_X);
    logic far, far_n;
    assign pts = far ? 4'd3 : 4'd2;
`else
    assign pts = 4'd1;
`endif

    always_comb begin
        state_n      = state;
        prev_y_n     = prev_y;
        prev_valid_n = prev_valid;
        hold_n       = hold_cnt;
        score_n      = score_bcd;
        shots_n      = shots_bcd;
        made_n       = 1'b0;
        missed_n     = 1'b0;
`ifdef SHOT_POINTS_EN
        far_n        = far;
`endif
        case (state)
            IDLE: begin
                if (launch) begin
                    state_n      = FLIGHT;
                    prev_valid_n = 1'b0;
                    shots_n      = bcd_add(shots_bcd, 4'd1);
                end
            end
            FLIGHT: begin
                if (frame_tick) begin
`ifdef SHOT_POINTS_EN
                    if (!prev_valid) far_n = (ball_x < THREE_PT_X_V);
`endif
                    if (hit) begin
                        score_n = bcd_add(score_bcd, pts);
                        made_n  = 1'b1;
                        state_n = HOLD;
                        hold_n  = HOLD_INIT;
                    end else if (out_of_play) begin
                        missed_n = 1'b1;
                        state_n  = HOLD;
                        hold_n   = HOLD_INIT;
                    end else begin
                        prev_y_n     = ball_y;
                        prev_valid_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt == '0) state_n = IDLE;
                    else                hold_n  = hold_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        flash_n = (state_n == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            hold_cnt   <= '0;
            score_bcd  <= 8'h00;
            shots_bcd  <= 8'h00;
            made       <= 1'b0;
            missed     <= 1'b0;
            flash      <= 1'b0;
`ifdef SHOT_POINTS_EN
            far        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            prev_y     <= prev_y_n;
            prev_valid <= prev_valid_n;
            hold_cnt   <= hold_n;
            score_bcd  <= score_n;
            shots_bcd  <= shots_n;
            made       <= made_n;
            missed     <= missed_n;
            flash      <= flash_n;
`ifdef SHOT_POINTS_EN
            far        <= far_n;
`endif
        end
    end

    assign state_o = state;

endmodule
